// File: rtl/fifo_pkg.sv
// fifo_pkg
// Definitions shared by fifo_flops and its serial drain (fifo_serial_tx):
//   - default word width and depth of the FIFO
//   - 3-bit encoding of the serial transmitter FSM states
//   - clog2_min1(): counter width helper that never returns 0
package fifo_pkg;

  localparam int FIFO_BITS_DEF  = 16;
  localparam int FIFO_DEPTH_DEF = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// baud_tick
// Bit-period timer. A down-counter that produces a one-cycle tick every
// CLKS_PER_BIT clocks. While restart is high the counter is held at its
// load value, so the first tick after restart drops comes exactly
// CLKS_PER_BIT cycles later.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low
//   restart  in   synchronous reload of the bit period
//   tick     out  high on the last cycle of each bit period
module baud_tick
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = clog2_min1(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Terminal count reloads, so back-to-back bits need no restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= CNT_LOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
// Drains a first-word-fall-through FIFO and sends each word as a UART-style
// frame: start bit (0), BITS data bits LSB first, stop bit (1), each bit
// CLKS_PER_BIT clocks long. The line idles high.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous reset, active low
//   Din     in   FIFO head word, valid while pndng=1
//   pndng   in   FIFO not empty
//   pop     out  one-cycle pop strobe (FETCH cycle)
//   enable  in   allows new frames to start
//   tx      out  serial line
//   busy    out  high from FETCH through the last STOP cycle
//   done    out  one-cycle pulse on the last STOP cycle
//
// state | meaning
// IDLE  | line high, waiting for pndng && enable
// FETCH | pop the head word, load it into the shift register
// START | start bit (0)
// DATA  | data bits, LSB first, shift after each bit
// STOP  | stop bit (1), done on its last cycle
module fifo_serial_tx
  import fifo_pkg::*;
#(
  parameter int BITS         = FIFO_BITS_DEF,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] Din,
  input  logic            pndng,
  output logic            pop,
  input  logic            enable,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int BW = clog2_min1(BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [BITS-1:0] shreg;
  logic [BW-1:0]   bit_cnt;
  logic            tick;
  logic            restart;
  logic            last_bit;
  logic            start_ok;

  // Holding the timer in IDLE/FETCH makes START begin with a full bit period.
  assign restart  = (state == ST_IDLE) || (state == ST_FETCH);
  assign last_bit = (bit_cnt == LAST_BIT);
  assign start_ok = pndng && enable;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_START;
      ST_START: if (tick) state_nxt = ST_DATA;
      ST_DATA:  if (tick && last_bit) state_nxt = ST_STOP;
      ST_STOP:  if (tick) state_nxt = start_ok ? ST_FETCH : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The FIFO drops its head on the same edge that closes FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == ST_FETCH) begin
        shreg <= Din;
      end else if ((state == ST_DATA) && tick) begin
        shreg <= shreg >> 1;
      end

      if (state != ST_DATA) begin
        bit_cnt <= '0;
      end else if (tick) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shreg[0];
      default:  tx = 1'b1;
    endcase
  end

  assign pop  = (state == ST_FETCH);
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_STOP) && tick;

endmodule
